// File: rtl/sound_scheduler.sv
// sound_scheduler: fixed-priority voice arbiter driving the sine-table phase accumulator and mute gate.
module sound_scheduler #(
  parameter int COUNT_SIZE = 8,
  parameter int NUM_REQ    = 4,
  parameter int PHASE_W    = 24,
  parameter int STEP_W     = 16,
  parameter int LEN_W      = 8,
  parameter int GAP_TICKS  = 2
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      tick,
  input  logic                      sample_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*STEP_W-1:0] step_bus,
  input  logic [NUM_REQ*LEN_W-1:0]  len_bus,
  output logic [COUNT_SIZE-1:0]     ADDR,
  output logic                      sound_on,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_TICKS + 2);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d, grant_q, grant_d, done_q, done_d;
  logic [NUM_REQ-1:0] av, win_oh;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [LEN_W-1:0] len_q, len_d, win_len, act_len;
  logic [GW-1:0] gap_q, gap_d;
  logic [COUNT_SIZE-1:0] addr_q, addr_d, top;
  logic sound_on_q, sound_on_d;
  logic [IW-1:0] win_idx, act_idx;
  logic load, preempt, restart, fin;
  always_comb begin
    av = pending_q | req;
    win_oh = av & (-av);
    win_idx = '0;
    act_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (av[i]) win_idx = i[IW-1:0];
      if (grant_q[i]) act_idx = i[IW-1:0];
    end
    win_len = len_bus[win_idx*LEN_W +: LEN_W];
    act_len = len_bus[act_idx*LEN_W +: LEN_W];
    preempt = (|av) && (win_oh < grant_q);
    restart = |(req & grant_q);
    fin = tick && (len_q == LEN_W'(1));
    state_d = state_q;
    pending_d = pending_q | req;
    phase_d = phase_q;
    step_d = step_q;
    len_d = len_q;
    gap_d = gap_q;
    grant_d = grant_q;
    done_d = '0;
    load = 1'b0;
    if (state_q == IDLE) load = |av;
    else if (state_q == PLAY) begin
      pending_d = pending_q | (req & ~grant_q);
      if (sample_en) phase_d = phase_q + PHASE_W'(step_q);
      if (tick) len_d = len_q - 1'b1;
      if (preempt) load = 1'b1;
      else if (restart) len_d = (act_len == '0) ? LEN_W'(1) : act_len;
      else if (fin) begin
        done_d = grant_q;
        grant_d = '0;
        if (GAP_TICKS > 0) begin
          state_d = GAP;
          gap_d = GW'(GAP_TICKS);
        end else if (|av) load = 1'b1;
        else state_d = IDLE;
      end
    end else if (tick) begin
      gap_d = gap_q - 1'b1;
      if (gap_q == GW'(1)) state_d = IDLE;
    end
    // Loading a voice restarts its phase and consumes its pending bit.
    if (load) begin
      state_d = PLAY;
      grant_d = win_oh;
      step_d = step_bus[win_idx*STEP_W +: STEP_W];
      len_d = (win_len == '0) ? LEN_W'(1) : win_len;
      phase_d = '0;
      pending_d = pending_d & ~win_oh;
    end
    // The last table entry is unused, so the top address folds down by one.
    top = phase_q[PHASE_W-1 -: COUNT_SIZE];
    addr_d = (state_q == PLAY) ? ((&top) ? top - 1'b1 : top) : '0;
    sound_on_d = state_q == PLAY;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      pending_q <= '0;
      phase_q <= '0;
      step_q <= '0;
      len_q <= '0;
      gap_q <= '0;
      grant_q <= '0;
      done_q <= '0;
      addr_q <= '0;
      sound_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      phase_q <= phase_d;
      step_q <= step_d;
      len_q <= len_d;
      gap_q <= gap_d;
      grant_q <= grant_d;
      done_q <= done_d;
      addr_q <= addr_d;
      sound_on_q <= sound_on_d;
    end
  end
  assign ADDR = addr_q;
  assign sound_on = sound_on_q;
  assign grant = grant_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler: directed checks of arbitration, phase/clamp, gap, preemption, restart and reset.
module tb_sound_scheduler;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic tick = 1'b0;
  logic sample_en = 1'b0;
  logic [3:0] req = '0;
  logic [63:0] step_bus = {16'h0300, 16'h0100, 16'h0200, 16'h0100};
  logic [31:0] len_bus = {8'd1, 8'd3, 8'd2, 8'd1};
  logic [7:0] ADDR;
  logic sound_on, busy;
  logic [3:0] grant, done;
  int n_chk = 0;
  int n_fail = 0;
  // A 16-bit phase makes a 0x0100 step advance the table address by one per sample.
  sound_scheduler #(.PHASE_W(16)) dut (
    .clk(clk), .resetN(resetN), .tick(tick), .sample_en(sample_en), .req(req),
    .step_bus(step_bus), .len_bus(len_bus), .ADDR(ADDR), .sound_on(sound_on),
    .grant(grant), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic [3:0] r, input logic t);
    req = r;
    tick = t;
    @(negedge clk);
    req = '0;
    tick = 1'b0;
  endtask
  task automatic gap_out();
    pulse(4'b0000, 1'b1);
    check("gap_busy_mid", 32'(busy), 1);
    pulse(4'b0000, 1'b1);
    check("gap_busy_end", 32'(busy), 0);
  endtask
  initial begin
    @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sound_on", 32'(sound_on), 0);
    check("rst_addr", 32'(ADDR), 0);
    check("rst_done", 32'(done), 0);
    resetN = 1'b1;
    sample_en = 1'b1;
    @(negedge clk);
    // single voice 2
    pulse(4'b0100, 1'b0);
    check("v2_grant", 32'(grant), 32'h4);
    check("v2_busy", 32'(busy), 1);
    check("v2_sound_lag", 32'(sound_on), 0);
    @(negedge clk);
    check("v2_sound_on", 32'(sound_on), 1);
    check("v2_addr0", 32'(ADDR), 0);
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (k == 1) check("v2_addr1", 32'(ADDR), 1);
      if (k == 2) check("v2_addr2", 32'(ADDR), 2);
      if (k == 254) check("addr_fe", 32'(ADDR), 32'hfe);
      if (k == 255) check("addr_clamp", 32'(ADDR), 32'hfe);
      if (k == 256) check("addr_wrap", 32'(ADDR), 0);
    end
    pulse(4'b0000, 1'b1);
    check("v2_no_done_early", 32'(done), 0);
    pulse(4'b0000, 1'b1);
    pulse(4'b0000, 1'b1);
    check("v2_done", 32'(done), 32'h4);
    check("v2_grant_off", 32'(grant), 0);
    check("v2_busy_gap", 32'(busy), 1);
    check("v2_sound_tail", 32'(sound_on), 1);
    @(negedge clk);
    check("v2_done_pulse", 32'(done), 0);
    check("v2_sound_off", 32'(sound_on), 0);
    check("v2_addr_off", 32'(ADDR), 0);
    gap_out();
    // preemption of voice 3 by voice 0
    pulse(4'b1000, 1'b0);
    check("v3_grant", 32'(grant), 32'h8);
    repeat (3) @(negedge clk);
    pulse(4'b0001, 1'b0);
    check("pre_grant", 32'(grant), 32'h1);
    check("pre_no_done", 32'(done), 0);
    @(negedge clk);
    check("pre_phase0", 32'(ADDR), 0);
    @(negedge clk);
    check("pre_phase1", 32'(ADDR), 1);
    pulse(4'b0000, 1'b1);
    check("pre_done0", 32'(done), 32'h1);
    gap_out();
    @(negedge clk);
    check("pre_no_requeue", 32'(grant), 0);
    // queueing of voice 3 behind voice 1
    pulse(4'b0010, 1'b0);
    check("q_v1_grant", 32'(grant), 32'h2);
    pulse(4'b1000, 1'b0);
    check("q_hold", 32'(grant), 32'h2);
    pulse(4'b0000, 1'b1);
    pulse(4'b0000, 1'b1);
    check("q_done1", 32'(done), 32'h2);
    pulse(4'b0000, 1'b1);
    check("q_gap_grant", 32'(grant), 0);
    pulse(4'b0000, 1'b1);
    check("q_gap_idle", 32'(busy), 0);
    @(negedge clk);
    check("q_v3_start", 32'(grant), 32'h8);
    pulse(4'b0000, 1'b1);
    check("q_done3", 32'(done), 32'h8);
    gap_out();
    // ending tick coinciding with req[0]
    pulse(4'b0100, 1'b0);
    pulse(4'b0000, 1'b1);
    pulse(4'b0000, 1'b1);
    pulse(4'b0001, 1'b1);
    check("same_grant", 32'(grant), 32'h1);
    check("same_no_done", 32'(done), 0);
    pulse(4'b0000, 1'b1);
    check("same_done0", 32'(done), 32'h1);
    gap_out();
    // restart at the ending tick
    pulse(4'b0100, 1'b0);
    pulse(4'b0000, 1'b1);
    pulse(4'b0000, 1'b1);
    pulse(4'b0100, 1'b1);
    check("rs_no_done", 32'(done), 0);
    check("rs_grant", 32'(grant), 32'h4);
    pulse(4'b0000, 1'b1);
    pulse(4'b0000, 1'b1);
    check("rs_no_done_2", 32'(done), 0);
    pulse(4'b0000, 1'b1);
    check("rs_done", 32'(done), 32'h4);
    gap_out();
    // asynchronous reset mid-play with a queued voice
    pulse(4'b0010, 1'b0);
    pulse(4'b1000, 1'b0);
    @(negedge clk);
    check("ar_pre_sound", 32'(sound_on), 1);
    #1 resetN = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_sound", 32'(sound_on), 0);
    check("ar_addr", 32'(ADDR), 0);
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_no_resume_grant", 32'(grant), 0);
    check("ar_no_resume_busy", 32'(busy), 0);
    check("ar_no_done", 32'(done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Multi-voice sound request scheduler that owns the shared sine-table tone generator in the audio path. Game logic raises one-cycle sound requests (shot, explosion, invader step, UFO). The block arbitrates them by fixed priority, runs a phase accumulator that drives the table address, times each sound's duration, and inserts a silent gap between consecutive sounds. Its outputs feed the table address input and the audio mute gate.

## Interface
- COUNT_SIZE, 8: table address width; the table holds 2^COUNT_SIZE-1 entries.
- NUM_REQ, 4: number of requesters; bit 0 has the highest priority.
- PHASE_W, 24: phase accumulator width (PHASE_W > COUNT_SIZE).
- STEP_W, 16: per-requester phase step width (STEP_W ≤ PHASE_W).
- LEN_W, 8: per-requester duration width, in tick units.
- GAP_TICKS, 2: silent ticks between sounds; 0 means no gap.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- tick  in  1  duration time-base strobe, one clk wide.
- sample_en  in  1  sample-rate strobe, one clk wide; advances the phase.
- req  in  NUM_REQ  one-cycle request pulses.
- step_bus  in  NUM_REQ*STEP_W  phase step for voice i at [i*STEP_W +: STEP_W]; sampled at voice start.
- len_bus  in  NUM_REQ*LEN_W  duration for voice i at [i*LEN_W +: LEN_W]; sampled at voice start and at restart.
- ADDR  out  COUNT_SIZE  table address.
- sound_on  out  1  audio gate, aligned with the table's one-cycle registered output.
- grant  out  NUM_REQ  one-hot active voice; all zeros when idle or in gap.
- done  out  NUM_REQ  one-cycle pulse when voice i completes normally.
- busy  out  1  high in PLAY or GAP.

## Operation
- Reset: state IDLE. pending, phase, counters, ADDR, grant, done, busy and sound_on are all 0.
- pending[i] is set by req[i] and cleared when voice i is loaded. Arbitration vector = pending | req; the lowest set index wins.
- States:
  - IDLE: if the arbitration vector is nonzero, load the winner and go to PLAY.
  - PLAY: on sample_en, phase <= phase + step (wraps mod 2^PHASE_W). On tick, len_cnt decrements; the tick that takes len_cnt from 1 to 0 ends the voice.
  - End of voice: pulse done[active]. Go to GAP if GAP_TICKS > 0; otherwise go to IDLE, or load the next winner directly if the arbitration vector is nonzero.
  - GAP: count GAP_TICKS ticks, then return to IDLE. New requests accumulate in pending during GAP; there is no preemption in GAP.
- Loading voice k: grant <= one-hot(k), step <= step_k, len_cnt <= len_k (a len of 0 is treated as 1), phase <= 0, pending[k] cleared.
- In PLAY, if a winner has a lower index than the active voice: preempt. Load the new voice at the next edge with no done for the abandoned voice. The abandoned voice is not re-queued.
- In PLAY, req[active]: restart. Reload len_cnt, keep the phase running, no done. A pending bit is not set.
- Requests with a higher index than the active voice stay pending.
- Simultaneous events in one cycle, in priority order: preemption, then restart, then normal end. If any of these three coincides with a higher-priority event, no done pulse is issued.
- ADDR = phase[PHASE_W-1 -: COUNT_SIZE], clamped so that 2^COUNT_SIZE-1 maps to 2^COUNT_SIZE-2. ADDR is forced to 0 outside PLAY.

## Timing
- req[i] high in cycle c while IDLE: grant and busy are high from c+1, and sound_on from c+2.
- sound_on is a registered copy of (state==PLAY) delayed one cycle. It falls one cycle after PLAY exits.
- ADDR is registered and updates the cycle after a sample_en.
- done is asserted in the cycle after the ending tick, together with the state change. grant goes 0 on the same edge.
- GAP lasts exactly GAP_TICKS tick strobes after the end of a voice.
- Asserting resetN low mid-sound clears all outputs immediately. No done pulse is issued.

## Test plan
- Single voice: req[2] pulse with step=0x0100, len=3, GAP_TICKS=2, sample_en every cycle.
  - ADDR = 0,1,2,… from c+2.
  - done[2] after the 3rd tick, busy falls after 2 more ticks, sound_on lags grant by 1 cycle.
- Clamp: step giving phase top byte 0xFF → ADDR reads 0xFE; the next wrap returns to 0x00.
- Preemption: voice 3 playing, req[0] pulse.
  - grant switches to 0001 on the next edge, phase restarts at 0.
  - No done[3]. Later done[0] only.
- Queueing: voice 1 playing, req[3] pulse. pending[3] is held; voice 3 starts after voice 1 ends plus the gap.
- Same-cycle events:
  - Ending tick and req[0] in the same cycle while voice 2 is active: no done[2], voice 0 loads.
  - req[active] at the ending tick: restart, no done.
- Async reset mid-PLAY: resetN low for 1 cycle. grant, busy, sound_on, ADDR and pending all read 0; no pending voice resumes.
